// File: rtl/uiwave_decim.sv
// rtl/uiwave_decim.sv - power-of-two ADC sample decimator (decimate / average / alternating peak)
//
// Purpose: reduces the raw 8-bit ADC stream by a timebase factor N = 2^n ahead of the
// waveform line buffer, with optional amplitude inversion.
//
// Ports:
//   I_wave_clk      sample clock (single clock domain)
//   I_wave_rst      asynchronous active-high reset
//   I_adc_data      raw ADC sample
//   I_adc_valid     I_adc_data valid this cycle
//   I_mode          0 decimate, 1 average, 2 alternating peak, 3 behaves as 0
//   I_div_log2      decimation exponent n, clamped to MAX_LOG2
//   I_invert        output 255 - value
//   I_clear         synchronous window restart (wins over I_adc_valid)
//   O_wave_data     conditioned sample, held between strobes
//   O_wave_data_de  one-cycle strobe per completed window
//   O_busy          window partially filled

module uiwave_decim #(
    parameter int MAX_LOG2 = 10,
    parameter int SUM_W    = 18
) (
    input  logic       I_wave_clk,
    input  logic       I_wave_rst,
    input  logic [7:0] I_adc_data,
    input  logic       I_adc_valid,
    input  logic [1:0] I_mode,
    input  logic [3:0] I_div_log2,
    input  logic       I_invert,
    input  logic       I_clear,
    output logic [7:0] O_wave_data,
    output logic       O_wave_data_de,
    output logic       O_busy
);

    localparam int         CNT_W = (MAX_LOG2 < 1) ? 1 : MAX_LOG2;
    localparam logic [3:0] MAX_N = 4'(MAX_LOG2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [7:0]       max_q, max_d;
    logic [7:0]       min_q, min_d;
    logic             phase_q, phase_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       n_q, n_d;
    logic             inv_q, inv_d;
    logic [7:0]       data_q, data_d;
    logic             de_q, de_d;
    logic             busy_q, busy_d;

    logic             first;
    logic             accept;
    logic             complete;
    logic [1:0]       eff_mode;
    logic [3:0]       eff_n;
    logic [3:0]       div_clamped;
    logic             eff_inv;
    logic [CNT_W-1:0] win_last;
    logic [SUM_W-1:0] sum_new;
    logic [7:0]       max_new;
    logic [7:0]       min_new;
    logic [7:0]       result;

    always_comb begin
        div_clamped = (I_div_log2 > MAX_N) ? MAX_N : I_div_log2;
        first       = (cnt_q == '0);
        accept      = I_adc_valid && !I_clear;

        // The sample that opens a window is processed with the config captured
        // on that same cycle, so n = 0 windows use the live inputs directly.
        eff_mode = first ? I_mode      : mode_q;
        eff_n    = first ? div_clamped : n_q;
        eff_inv  = first ? I_invert    : inv_q;

        win_last = CNT_W'((32'd1 << eff_n) - 32'd1);
        complete = accept && (cnt_q == win_last);

        sum_new = acc_q + SUM_W'(I_adc_data);
        max_new = (I_adc_data > max_q) ? I_adc_data : max_q;
        min_new = (I_adc_data < min_q) ? I_adc_data : min_q;

        case (eff_mode)
            2'd1:    result = 8'(sum_new >> eff_n);
            2'd2:    result = phase_q ? min_new : max_new;
            default: result = I_adc_data;
        endcase

        cnt_d   = cnt_q;
        acc_d   = acc_q;
        max_d   = max_q;
        min_d   = min_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        n_d     = n_q;
        inv_d   = inv_q;
        data_d  = data_q;
        de_d    = 1'b0;

        if (I_clear) begin
            cnt_d   = '0;
            acc_d   = '0;
            max_d   = 8'd0;
            min_d   = 8'd255;
            phase_d = 1'b0;
        end else if (accept) begin
            if (first) begin
                mode_d = I_mode;
                n_d    = div_clamped;
                inv_d  = I_invert;
            end
            if (complete) begin
                cnt_d  = '0;
                acc_d  = '0;
                max_d  = 8'd0;
                min_d  = 8'd255;
                de_d   = 1'b1;
                data_d = eff_inv ? ~result : result;
                if (eff_mode == 2'd2) begin
                    phase_d = ~phase_q;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = sum_new;
                max_d = max_new;
                min_d = min_new;
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge I_wave_clk or posedge I_wave_rst) begin
        if (I_wave_rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            max_q   <= 8'd0;
            min_q   <= 8'd255;
            phase_q <= 1'b0;
            mode_q  <= 2'd0;
            n_q     <= 4'd0;
            inv_q   <= 1'b0;
            data_q  <= 8'd0;
            de_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            min_q   <= min_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            n_q     <= n_d;
            inv_q   <= inv_d;
            data_q  <= data_d;
            de_q    <= de_d;
            busy_q  <= busy_d;
        end
    end

    assign O_wave_data    = data_q;
    assign O_wave_data_de = de_q;
    assign O_busy         = busy_q;

endmodule

// File: tb/tb_uiwave_decim.sv
// tb/tb_uiwave_decim.sv - self-checking bench for uiwave_decim
module tb_uiwave_decim;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] adc_data = 8'd0;
    logic       adc_valid = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] div_log2 = 4'd0;
    logic       invert = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] wave_data;
    logic       wave_de;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] exp_data_q[$];
    int         exp_cyc_q[$];

    uiwave_decim #(.MAX_LOG2(10), .SUM_W(18)) dut (
        .I_wave_clk    (clk),
        .I_wave_rst    (rst),
        .I_adc_data    (adc_data),
        .I_adc_valid   (adc_valid),
        .I_mode        (mode),
        .I_div_log2    (div_log2),
        .I_invert      (invert),
        .I_clear       (clear),
        .O_wave_data   (wave_data),
        .O_wave_data_de(wave_de),
        .O_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expectation in value and cycle.
    always @(negedge clk) begin
        if (wave_de) begin
            checks++;
            if (exp_data_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got data=%0d at cycle %0d, none expected", wave_data, cyc);
            end else begin
                logic [7:0] ed;
                int         ec;
                ed = exp_data_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (wave_data !== ed || cyc != ec) begin
                    failures++;
                    $display("FAIL strobe: got data=%0d cycle=%0d, expected data=%0d cycle=%0d", wave_data, cyc, ed, ec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Present one input cycle; it is accepted at the following rising edge and,
    // if it completes a window, the strobe is visible in the cycle after that edge.
    task automatic put(input logic [7:0] d, input logic v, input logic c,
                       input logic exp_en, input logic [7:0] exp_d);
        @(posedge clk);
        #1;
        adc_data  = d;
        adc_valid = v;
        clear     = c;
        if (exp_en) begin
            exp_data_q.push_back(exp_d);
            exp_cyc_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wave_data !== 8'd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", wave_data); end
        checks++;
        if (wave_de !== 1'b0) begin failures++; $display("FAIL reset_de: got %0b expected 0", wave_de); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_decimate;
        mode = 2'd0; div_log2 = 4'd2; invert = 1'b0;
        put(8'd10, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd20, 1'b1, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL decim_busy: got %0b expected 1", busy); end
        put(8'd30, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd40, 1'b1, 1'b0, 1'b1, 8'd40);
        put(8'd50, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd60, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd70, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd80, 1'b1, 1'b0, 1'b1, 8'd80);
        idle(3);
        checks++;
        if (wave_data !== 8'd80) begin failures++; $display("FAIL decim_hold: got %0d expected 80", wave_data); end
    endtask

    task automatic test_average;
        mode = 2'd1; div_log2 = 4'd2; invert = 1'b0;
        put(8'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd4, 1'b1, 1'b0, 1'b1, 8'd2);
        for (int i = 0; i < 4; i++) put(8'd255, 1'b1, 1'b0, (i == 3), 8'd255);
        idle(2);
    endtask

    task automatic test_peak;
        mode = 2'd2; div_log2 = 4'd1; invert = 1'b0;
        put(8'd5,   1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd9,   1'b1, 1'b0, 1'b1, 8'd9);
        put(8'd200, 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd7,   1'b1, 1'b0, 1'b1, 8'd7);
        put(8'd3,   1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd100, 1'b1, 1'b0, 1'b1, 8'd100);
        idle(2);
    endtask

    task automatic test_back_to_back;
        mode = 2'd0; div_log2 = 4'd0; invert = 1'b1;
        put(8'd0,   1'b1, 1'b0, 1'b1, 8'd255);
        put(8'd255, 1'b1, 1'b0, 1'b1, 8'd0);
        put(8'd100, 1'b1, 1'b0, 1'b1, 8'd155);
        idle(2);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_shadow_config;
        logic [7:0] s [8];
        int k;
        s = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        mode = 2'd1; div_log2 = 4'd3; invert = 1'b0;
        k = 0;
        while (k < 8) begin
            if (k == 3) div_log2 = 4'd0;
            put(s[k], 1'b1, 1'b0, (k == 7), 8'd45);  // 360 >> 3
            if (k < 7) put(8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
            k++;
        end
        put(8'd77,  1'b1, 1'b0, 1'b1, 8'd77);
        put(8'd200, 1'b1, 1'b0, 1'b1, 8'd200);
        idle(2);
    endtask

    task automatic test_clear;
        mode = 2'd0; div_log2 = 4'd3; invert = 1'b0;
        for (int i = 0; i < 5; i++) put(8'(i + 100), 1'b1, 1'b0, 1'b0, 8'd0);
        put(8'd99, 1'b1, 1'b1, 1'b0, 8'd0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy_before: got %0b expected 1", busy); end
        idle(1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy_after: got %0b expected 0", busy); end
        for (int i = 1; i <= 8; i++) put(8'(i), 1'b1, 1'b0, (i == 8), 8'd8);
        idle(2);
    endtask

    task automatic test_midreset;
        mode = 2'd0; div_log2 = 4'd3; invert = 1'b0;
        for (int i = 0; i < 3; i++) put(8'd50, 1'b1, 1'b0, 1'b0, 8'd0);
        idle(1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wave_data !== 8'd0) begin failures++; $display("FAIL midrst_data: got %0d expected 0", wave_data); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        checks++;
        if (wave_de !== 1'b0) begin failures++; $display("FAIL midrst_de: got %0b expected 0", wave_de); end
        #3 rst = 1'b0;
        idle(4);
        div_log2 = 4'd0;
        put(8'd42, 1'b1, 1'b0, 1'b1, 8'd42);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_decimate();
        test_average();
        test_peak();
        test_back_to_back();
        test_shadow_config();
        test_clear();
        test_midreset();
        checks++;
        if (exp_data_q.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes: got %0d outstanding, expected 0", exp_data_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uiwave_decim.md
Name: uiwave_decim

Overview:
- Sample conditioner directly upstream of the waveform ping-pong line buffer.
- Takes the raw 8-bit ADC stream in the wave clock domain and reduces it by a power-of-two timebase factor, using one of three modes: plain decimation, box averaging or alternating peak detection.
- Optionally inverts amplitude for screen orientation.
- Produces the 8-bit sample / data-enable pair consumed as the buffer's write data and write-data-valid.

Parameters:
- MAX_LOG2, 10: largest decimation exponent supported; window length N = 2^n, n = 0..MAX_LOG2.
- SUM_W, 18: accumulator width; must be at least 8 + MAX_LOG2.

Ports:
- I_wave_clk  in  1  sample clock, same as ADC capture clock; single clock domain.
- I_wave_rst  in  1  reset, asynchronous, active-high.
- I_adc_data  in  8  raw ADC sample.
- I_adc_valid  in  1  I_adc_data valid this cycle.
- I_mode  in  2  0 = decimate (last sample of window), 1 = average, 2 = peak, 3 = treated as 0.
- I_div_log2  in  4  decimation exponent n; values > MAX_LOG2 clamp to MAX_LOG2.
- I_invert  in  1  1: output 255 - value.
- I_clear  in  1  synchronous window restart, e.g. on trigger re-arm.
- O_wave_data  out  8  conditioned sample.
- O_wave_data_de  out  1  one-cycle strobe, O_wave_data valid.
- O_busy  out  1  window partially filled (count != 0).

Behaviour:
- Reset (asynchronous on I_wave_rst high):
  - O_wave_data = 0, O_wave_data_de = 0, O_busy = 0.
  - Count = 0, accumulator = 0, max = 0, min = 255, peak phase = 0 (max first).
  - Shadow config: mode 0, n 0, invert 0.
- Shadow config:
  - I_mode, clamped I_div_log2 and I_invert are captured on the cycle that accepts the first valid sample of a window (count == 0 and I_adc_valid).
  - Mid-window input changes are ignored until the next window.
- Window accumulation:
  - Each accepted sample increments count.
  - The window completes on the accepted sample where count == N-1; count then returns to 0.
  - If n = 0, every valid sample completes a window.
- Per-mode result, computed using the completing sample itself:
  - Mode 0: the completing sample.
  - Mode 1: (sum of N samples) >> n, truncating; the sum is SUM_W bits and never overflows.
  - Mode 2: window max when peak phase = 0, window min when peak phase = 1; phase toggles after each completed window.
  - Mode 2 with n = 0: max = min = sample, so the output equals the input and the phase still toggles.
- Output stage:
  - O_wave_data and O_wave_data_de are registered on the cycle after the completing sample; latency 1 clock.
  - Value is inverted if shadow invert = 1.
  - O_wave_data holds its value between strobes.
  - O_wave_data_de is high exactly one cycle per window and is never high on consecutive cycles unless n = 0 with back-to-back valid input.
- At window completion, accumulator, max and min reload to their initial values (0 / 0 / 255) so the next window starts clean.
- I_adc_valid low: no state change; gaps in valid input do not break a window.
- I_clear:
  - Same cycle: count = 0, accumulator/max/min re-initialised, peak phase = 0, partial window discarded, no strobe generated.
  - An output strobe already registered from the previous cycle is still presented.
  - If I_clear and I_adc_valid are high together, I_clear wins and the sample is dropped.
- O_busy = (count != 0), registered.
- Mid-operation reset: all state returns to reset values immediately; no partial strobe is produced after release.

Test Plan:
- Mode 0, n = 2, invert 0, valid every cycle, samples 10,20,30,40,50,60,70,80 -> exactly two strobes, data 40 then 80, each 1 cycle after the 4th/8th sample.
- Mode 1, n = 2, samples 1,2,3,4 -> single strobe with data 2 (10 >> 2, truncation); samples 255 ×4 -> 255 (no overflow).
- Mode 2, n = 1, samples 5,9,200,7 -> strobes 9 (max, phase 0) then 7 (min, phase 1); next window 3,100 -> 100.
- Mode 0, n = 0, invert 1, samples 0,255,100 back-to-back -> three consecutive strobes 255,0,155.
- Mode 1, n = 3, I_div_log2 changed to 0 after 3 samples, I_adc_valid toggled 50% -> window still completes after 8 valid samples using n = 3; the following window uses n = 0.
- Mode 0, n = 3, I_clear asserted after 5 samples -> no strobe, O_busy drops next cycle; 8 further samples produce one strobe. Assert I_wave_rst mid-window -> outputs 0 asynchronously, O_busy = 0.
